// File: rtl/poly_addsub_ctrl_pkg.sv
// Shared constants and FSM state type for the polynomial add/subtract sequencer.
// Kyber field parameters live here so the datapath and the sequencer agree on them.
package poly_addsub_ctrl_pkg;

   localparam int unsigned DWIDTH  = 12;
   localparam int unsigned KYBER_Q = 3329;
   localparam int unsigned KYBER_N = 256;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDrain,
      StFin
   } state_e;

endpackage

// File: rtl/mod_add.sv
// Modular adder: sum_o = (a_i + b_i) mod Q for operands already reduced below Q.
// The add is done in DW+1 bits so the carry is never lost before the conditional subtract.
module mod_add #(
   parameter int unsigned DW = 12,
   parameter int unsigned Q  = 3329
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] sum_o
);

   localparam logic [DW:0] QW = (DW+1)'(Q);

   logic [DW:0] raw;

   assign raw   = {1'b0, a_i} + {1'b0, b_i};
   assign sum_o = DW'((raw >= QW) ? raw - QW : raw);

endmodule

// File: rtl/poly_addsub_ctrl.sv
// Streams one polynomial pair from two source RAMs through a single mod_add and writes
// c = a + b or c = a - b (mod q) to a destination RAM, one coefficient per cycle.
module poly_addsub_ctrl
   import poly_addsub_ctrl_pkg::*;
#(
   parameter int unsigned N  = KYBER_N,
   parameter int unsigned AW = $clog2(N),
   parameter int unsigned DW = DWIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          op_sub,
   output logic          busy,
   output logic          done,
   output logic          err_range,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rdata_a,
   input  logic [DW-1:0] rdata_b,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data
);

   localparam logic [DW-1:0] QV    = DW'(KYBER_Q);
   localparam logic [AW-1:0] LastA = AW'(N - 1);

   state_e        state_q, state_d;
   logic          op_sub_q, op_sub_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          v1_q, v1_d;
   logic [AW-1:0] addr1_q, addr1_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic [DW-1:0] b_cond;
   logic [DW-1:0] sum;

   // Subtraction reuses the adder as a + (q - b); b == 0 must map to 0, not q.
   assign b_cond = (!op_sub_q || rdata_b == '0) ? rdata_b
                                                : DW'((DW+1)'(KYBER_Q) - {1'b0, rdata_b});

   mod_add #(
      .DW (DW),
      .Q  (KYBER_Q)
   ) u_mod_add (
      .a_i   (rdata_a),
      .b_i   (b_cond),
      .sum_o (sum)
   );

   always_comb begin
      state_d   = state_q;
      op_sub_d  = op_sub_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      // v1 marks the cycle in which RAM data for addr1 is on rdata_a/rdata_b.
      v1_d      = rd_en_q;
      addr1_d   = rd_addr_q;
      wr_en_d   = v1_q;
      wr_addr_d = addr1_q;
      wr_data_d = v1_q ? sum : wr_data_q;

      if (v1_q && (rdata_a >= QV || rdata_b >= QV)) begin
         err_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               op_sub_d  = op_sub;
               err_d     = 1'b0;
               busy_d    = 1'b1;
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               state_d   = StRead;
            end
         end
         StRead: begin
            if (rd_addr_q == LastA) begin
               rd_en_d = 1'b0;
               state_d = StDrain;
            end else begin
               rd_addr_d = rd_addr_q + AW'(1);
            end
         end
         StDrain: begin
            if (v1_q && addr1_q == LastA) begin
               state_d = StFin;
            end
         end
         StFin: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         op_sub_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         v1_q      <= 1'b0;
         addr1_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_sub_q  <= op_sub_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         v1_q      <= v1_d;
         addr1_q   <= addr1_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err_range = err_q;
   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule
